// File: rtl/npu_dot_acc.sv
// -----------------------------------------------------------------------------
// npu_dot_acc
//   Streaming multi-lane dot-product accumulator.
//
//   Each accepted beat carries LANES activation/weight pairs. The pairs are
//   multiplied lane by lane, and the products are reduced to one beat sum. That
//   sum is added into a saturating accumulator. The beat flagged in_last closes
//   the vector: its saturated total goes to out_data, and the accumulator and
//   the sticky saturation flag restart from zero.
//
//   Pipeline (one register per stage, all advancing together):
//     s1 : LANES signed lane products        + valid/last
//     s2 : signed SUM_W-bit beat sum         + valid/last
//     s3 : beat sum sign-extended to ACC_W   + valid/last
//     acc/out : saturating acc + s3 sum, written to acc or to out_data
//   A last beat accepted at edge N raises out_valid after edge N+3.
//
//   Handshake semantics (both ports): a transfer happens on a rising edge
//   where valid & ready are both 1. A producer that raises valid keeps it and
//   its payload stable until the transfer. ready may depend combinationally on
//   the other side. This block's in_ready is ~(out_valid & ~out_ready). A
//   pending, unconsumed result therefore freezes the whole pipeline, and a
//   consumer that pulls the result lets a new beat in on the same edge.
//
// Parameters
//   LANES  multiply lanes per beat (power of two, 2..64)
//   DW     operand width per lane
//   ACC_W  accumulator / result width, must be >= SUM_W = 2*DW+1+log2(LANES)
//
// Ports
//   clk             clock, all state on the rising edge
//   rst_n           asynchronous active-low reset
//   in_valid        beat offered
//   in_ready        beat accepted when in_valid & in_ready
//   in_data         activation lanes, lane i at [i*DW +: DW]
//   in_para         weight lanes, always two's complement
//   is_signed_data  1: in_data lanes signed, 0: unsigned (per beat)
//   in_last         final beat of the current vector
//   out_valid       result held
//   out_ready       result consumed when out_valid & out_ready
//   out_data        signed accumulated dot product
//   out_sat         saturation occurred somewhere within this vector
// -----------------------------------------------------------------------------
module npu_dot_acc #(
  parameter int LANES = 8,
  parameter int DW    = 8,
  parameter int ACC_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*DW-1:0]   in_data,
  input  logic [LANES*DW-1:0]   in_para,
  input  logic                  is_signed_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out_data,
  output logic                  out_sat
);

  localparam int PW    = 2*DW + 1;                 // lane product width
  localparam int SUM_W = PW + $clog2(LANES);       // beat sum width
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] ACC_MAX = ~ACC_MIN;

  // ---------------------------------------------------------------------------
  // Flow control: a held result that is not being consumed freezes everything.
  // ---------------------------------------------------------------------------
  logic stall;
  logic adv;

  assign stall    = out_valid & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = ~stall;

  // ---------------------------------------------------------------------------
  // Lane multiply. Data is widened to DW+1 bits with sign or zero extension,
  // which lets one signed multiplier cover both data modes. Both operands are
  // then brought to PW bits so the product is a plain PW x PW signed multiply.
  // ---------------------------------------------------------------------------
  function automatic logic signed [PW-1:0] lane_mul(
    input logic [DW-1:0] d,
    input logic [DW-1:0] p,
    input logic          sgn
  );
    logic        [DW:0]   d_ext;
    logic signed [PW-1:0] a;
    logic signed [PW-1:0] b;
    d_ext = {sgn & d[DW-1], d};
    a     = {{DW{d_ext[DW]}}, d_ext};
    b     = {{(DW+1){p[DW-1]}}, p};
    return a * b;
  endfunction

  logic signed [PW-1:0] prod_c [LANES];

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod_c[i] = lane_mul(in_data[i*DW +: DW], in_para[i*DW +: DW], is_signed_data);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------------
  logic                 s1_valid;
  logic                 s1_last;
  logic signed [PW-1:0] s1_prod [LANES];

  // ---------------------------------------------------------------------------
  // Lane reduction. SUM_W leaves log2(LANES) guard bits, so the sum of LANES
  // products cannot overflow.
  // ---------------------------------------------------------------------------
  logic signed [SUM_W-1:0] sum_c;

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_c = sum_c + {{(SUM_W-PW){s1_prod[i][PW-1]}}, s1_prod[i]};
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 registers
  // ---------------------------------------------------------------------------
  logic                    s2_valid;
  logic                    s2_last;
  logic signed [SUM_W-1:0] s2_sum;

  // The beat sum is widened to ACC_W before it is registered. The saturating
  // add then starts straight from flops on both operands.
  logic [ACC_W-1:0] sum_ext;

  generate
    if (ACC_W > SUM_W) begin : g_widen
      assign sum_ext = {{(ACC_W-SUM_W){s2_sum[SUM_W-1]}}, s2_sum};
    end else begin : g_same
      assign sum_ext = s2_sum;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Stage 3 registers and accumulator state
  // ---------------------------------------------------------------------------
  logic             s3_valid;
  logic             s3_last;
  logic [ACC_W-1:0] s3_sum;
  logic [ACC_W-1:0] acc;
  logic             sticky;

  // ---------------------------------------------------------------------------
  // Saturating add. The operands are widened by one bit. A disagreement between
  // the top two bits of the result means it left the signed ACC_W range, and
  // the top bit then gives the direction of the overflow.
  // ---------------------------------------------------------------------------
  logic [ACC_W:0]   wide_sum;
  logic             ovf;
  logic [ACC_W-1:0] sat_val;

  always_comb begin
    wide_sum = {acc[ACC_W-1], acc} + {s3_sum[ACC_W-1], s3_sum};
    ovf      = wide_sum[ACC_W] ^ wide_sum[ACC_W-1];
    if (ovf) begin
      sat_val = wide_sum[ACC_W] ? ACC_MIN : ACC_MAX;
    end else begin
      sat_val = wide_sum[ACC_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential state. Everything advances only when not stalled. Bubbles
  // (valid = 0) move through the valid pipeline without touching the data
  // registers, acc, sticky or the outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        s1_prod[i] <= '0;
      end
      s2_valid  <= 1'b0;
      s2_last   <= 1'b0;
      s2_sum    <= '0;
      s3_valid  <= 1'b0;
      s3_last   <= 1'b0;
      s3_sum    <= '0;
      acc       <= '0;
      sticky    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (adv) begin
      // stage 1: in_ready is 1 whenever we advance, so in_valid alone
      // decides whether a beat was accepted
      s1_valid <= in_valid;
      s1_last  <= in_valid & in_last;
      if (in_valid) begin
        for (int i = 0; i < LANES; i++) begin
          s1_prod[i] <= prod_c[i];
        end
      end

      // stage 2
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      if (s1_valid) begin
        s2_sum <= sum_c;
      end

      // stage 3
      s3_valid <= s2_valid;
      s3_last  <= s2_last;
      if (s2_valid) begin
        s3_sum <= sum_ext;
      end

      // accumulate / emit
      if (s3_valid) begin
        if (s3_last) begin
          acc      <= '0;
          sticky   <= 1'b0;
          out_data <= sat_val;
          out_sat  <= sticky | ovf;
        end else begin
          acc      <= sat_val;
          sticky   <= sticky | ovf;
        end
      end

      // While advancing, a held result is being consumed on this edge. It is
      // therefore replaced by a newly completed vector or dropped.
      out_valid <= s3_valid & s3_last;
    end
  end

endmodule
